sobel_frame_sequencer: RTL and testbench
========================================

// Module: sobel_frame_sequencer
// PURPOSE
// Frame-level scheduler for the Sobel window engine. Walks a grayscale frame in a source
// memory, streams pixels to the engine in window order (full 9-pixel load at top of each
// column strip, 3-pixel bottom-row update per step down), and writes each returned
// gradient pixel to its interior position in a destination memory.
// PARAMETERS
// PIXEL_WIDTH  8   pixel bit width (source, engine, destination)
// DIM_BITS     10  width of frame width/height config
// ADDR_WIDTH   20  memory address width (>= 2*DIM_BITS)
// PORTS
// clk_i           in   1            clock, rising edge
// reset_i         in   1            asynchronous reset, active-high
// start_i         in   1            frame start request (sampled in IDLE only)
// cfg_width_i     in   DIM_BITS     frame width W in pixels (sampled on accepted start)
// cfg_height_i    in   DIM_BITS     frame height H in pixels (sampled on accepted start)
// busy_o          out  1            frame in progress
// done_o          out  1            1-cycle pulse: frame complete or rejected
// err_o           out  1            config error (W<3 or H<3); held until next accepted start
// rd_en_o         out  1            source read strobe
// rd_addr_o       out  ADDR_WIDTH   source address = row*W + col
// rd_data_i       in   PIXEL_WIDTH  source data, valid exactly 1 cycle after rd_en_o
// eng_start_o     out  1            1-cycle pulse on frame start (engine clears window)
// eng_px_o        out  PIXEL_WIDTH  pixel to engine
// eng_px_valid_o  out  1            eng_px_o valid
// eng_load9_o     out  1            with valid: pixel is part of a full 9-pixel load
// eng_ready_i     in   1            engine accepts pixel when valid&&ready
// eng_res_i       in   PIXEL_WIDTH  gradient result
// eng_res_valid_i in   1            result valid (1 cycle, in window order)
// wr_en_o         out  1            destination write strobe
// wr_addr_o       out  ADDR_WIDTH   destination address
// wr_data_o       out  PIXEL_WIDTH  destination data
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters, FIFO, in-flight flag cleared. Reset mid-frame aborts, no done_o.
// - FSM: IDLE -start_i-> CHECK (latch W,H, pulse eng_start_o unless error).
//   CHECK: W<3|H<3 -> set err_o, pulse done_o, IDLE (no reads). Else clear err_o -> FETCH.
//   FETCH: issue reads; after last read issued -> DRAIN. DRAIN: when last result written -> DONE.
//   DONE: pulse done_o, -> IDLE. busy_o=1 in CHECK/FETCH/DRAIN/DONE. start_i ignored when busy.
// - Read order: strips c=0..W-3; within strip r=0..H-3.
//   r==0: 9 reads rows r..r+2, cols c..c+2, row-major, eng_load9_o=1.
//   r>0: 3 reads row r+2, cols c..c+2, eng_load9_o=0. Total reads (W-2)*(9+3*(H-3)).
// - Buffering: 2-entry pixel FIFO toward engine; rd_en_o only when occupancy + in-flight < 2.
//   Read data pushed into FIFO the cycle after rd_en_o. Head of FIFO drives eng_px_o/valid/load9.
//   No pixel dropped or duplicated under any eng_ready_i pattern; full throughput 1 px/cycle when ready held.
// - Results: output counters (oc,or) follow same strip order; on eng_res_valid_i in FETCH/DRAIN:
//   wr_en_o=1 next cycle, wr_addr_o=(or+1)*W+(oc+1), wr_data_o=eng_res_i. Expected (W-2)*(H-2) writes.
//   eng_res_valid_i in IDLE/CHECK/DONE or after last expected result: ignored.
// - Address arithmetic unsigned, ADDR_WIDTH bits; no wrap for W,H < 2^DIM_BITS.
// - Results may arrive while reads still issuing; read and write paths are independent.
// TESTING
// 1) W=3,H=3, ready=1: 9 reads addr 0..8 all load9=1; one result -> single write addr 4; done_o 1 pulse.
// 2) W=4,H=4: 24 reads (0,1,2,4,5,6,8,9,10 | 12,13,14 | 1,2,3,5,6,7,9,10,11 | 13,14,15); writes 5,9,6,10.
// 3) W=2,H=5 start: err_o=1, done_o pulse next-but-one cycle, rd_en_o never 1; next valid start clears err_o.
// 4) W=5,H=4, eng_ready_i low 10 cycles mid 9-load: FIFO<=2, rd_en_o stalls, pixel sequence identical to case with ready=1.
// 5) reset_i pulsed mid-FETCH of W=8,H=8: all outputs 0 next cycle, no done_o; fresh start runs correctly.
// 6) start_i held during busy and stray eng_res_valid_i in IDLE: no restart, no extra writes.

Source files
------------

// File: rtl/sobel_frame_sequencer.sv
// Frame scheduler for the Sobel window engine: walks the source frame in
// column-strip window order, feeds the engine and writes results back.
module sobel_frame_sequencer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int DIM_BITS    = 10,
    parameter int ADDR_WIDTH  = 20
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [DIM_BITS-1:0]    cfg_width_i,
    input  logic [DIM_BITS-1:0]    cfg_height_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   rd_en_o,
    output logic [ADDR_WIDTH-1:0]  rd_addr_o,
    input  logic [PIXEL_WIDTH-1:0] rd_data_i,
    output logic                   eng_start_o,
    output logic [PIXEL_WIDTH-1:0] eng_px_o,
    output logic                   eng_px_valid_o,
    output logic                   eng_load9_o,
    input  logic                   eng_ready_i,
    input  logic [PIXEL_WIDTH-1:0] eng_res_i,
    input  logic                   eng_res_valid_i,
    output logic                   wr_en_o,
    output logic [ADDR_WIDTH-1:0]  wr_addr_o,
    output logic [PIXEL_WIDTH-1:0] wr_data_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;

    logic [DIM_BITS-1:0]  w_q, h_q;
    logic [DIM_BITS-1:0]  rc, rr, oc, orow;
    logic [1:0]           dx, dy;
    logic                 infl, infl_l9, res_done;
    logic [PIXEL_WIDTH:0] fifo [2];
    logic                 wp, rp;
    logic [1:0]           cnt;

    logic                  cfg_bad, load9, burst_end, strip_end, last_read;
    logic                  pop, res_take, res_last;
    logic [2:0]            occ_n;
    logic [ADDR_WIDTH-1:0] rd_row, rd_addr, wr_addr;

    assign cfg_bad   = (cfg_width_i < DIM_BITS'(3)) || (cfg_height_i < DIM_BITS'(3));
    assign load9     = (rr == '0);
    assign burst_end = (dx == 2'd2) && (!load9 || dy == 2'd2);
    assign strip_end = (rr == h_q - DIM_BITS'(3));
    assign last_read = burst_end && strip_end && (rc == w_q - DIM_BITS'(3));

    // A head pixel leaving this cycle frees its slot for the next read.
    assign pop   = eng_px_valid_o && eng_ready_i;
    assign occ_n = {1'b0, cnt} + {2'b0, infl} - {2'b0, pop};

    assign busy_o  = (state != S_IDLE);
    assign rd_en_o = (state == S_FETCH) && (occ_n < 3'd2);

    assign rd_row  = ADDR_WIDTH'(rr) + ADDR_WIDTH'(load9 ? dy : 2'd2);
    assign rd_addr = rd_row * ADDR_WIDTH'(w_q)
                   + ADDR_WIDTH'(rc) + ADDR_WIDTH'(dx);
    assign rd_addr_o = rd_en_o ? rd_addr : '0;

    assign eng_px_valid_o = (cnt != 2'd0);
    assign eng_px_o    = eng_px_valid_o ? fifo[rp][PIXEL_WIDTH-1:0] : '0;
    assign eng_load9_o = eng_px_valid_o && fifo[rp][PIXEL_WIDTH];

    assign res_take = eng_res_valid_i && !res_done
                   && (state == S_FETCH || state == S_DRAIN);
    assign res_last = (orow == h_q - DIM_BITS'(3)) && (oc == w_q - DIM_BITS'(3));
    assign wr_addr  = (ADDR_WIDTH'(orow) + ADDR_WIDTH'(1)) * ADDR_WIDTH'(w_q)
                    + ADDR_WIDTH'(oc) + ADDR_WIDTH'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            w_q         <= '0;
            h_q         <= '0;
            rc          <= '0;
            rr          <= '0;
            oc          <= '0;
            orow        <= '0;
            dx          <= '0;
            dy          <= '0;
            infl        <= 1'b0;
            infl_l9     <= 1'b0;
            res_done    <= 1'b0;
            fifo[0]     <= '0;
            fifo[1]     <= '0;
            wp          <= 1'b0;
            rp          <= 1'b0;
            cnt         <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            eng_start_o <= 1'b0;
            wr_en_o     <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
        end else begin
            eng_start_o <= 1'b0;
            done_o      <= 1'b0;
            wr_en_o     <= 1'b0;

            infl    <= rd_en_o;
            infl_l9 <= load9;

            if (infl) begin
                fifo[wp] <= {infl_l9, rd_data_i};
                wp       <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            cnt <= cnt + 2'(infl) - 2'(pop);

            if (rd_en_o) begin
                if (burst_end) begin
                    dx <= '0;
                    dy <= '0;
                    if (strip_end) begin
                        rr <= '0;
                        rc <= rc + DIM_BITS'(1);
                    end else begin
                        rr <= rr + DIM_BITS'(1);
                    end
                end else if (dx == 2'd2) begin
                    dx <= '0;
                    dy <= dy + 2'd1;
                end else begin
                    dx <= dx + 2'd1;
                end
            end

            if (res_take) begin
                wr_en_o   <= 1'b1;
                wr_addr_o <= wr_addr;
                wr_data_o <= eng_res_i;
                if (res_last) begin
                    res_done <= 1'b1;
                end else if (orow == h_q - DIM_BITS'(3)) begin
                    orow <= '0;
                    oc   <= oc + DIM_BITS'(1);
                end else begin
                    orow <= orow + DIM_BITS'(1);
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        w_q         <= cfg_width_i;
                        h_q         <= cfg_height_i;
                        eng_start_o <= !cfg_bad;
                        state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_q < DIM_BITS'(3) || h_q < DIM_BITS'(3)) begin
                        err_o  <= 1'b1;
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        err_o    <= 1'b0;
                        rc       <= '0;
                        rr       <= '0;
                        dx       <= '0;
                        dy       <= '0;
                        oc       <= '0;
                        orow     <= '0;
                        res_done <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (rd_en_o && last_read)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (res_done) begin
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer: memory and engine models plus
// scoreboards for read addresses, engine pixels and destination writes.
module tb_sobel_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [9:0]  cfg_width_i = '0;
    logic [9:0]  cfg_height_i = '0;
    logic        busy_o, done_o, err_o, rd_en_o;
    logic [19:0] rd_addr_o;
    logic [7:0]  rd_data_i = '0;
    logic        eng_start_o;
    logic [7:0]  eng_px_o;
    logic        eng_px_valid_o, eng_load9_o;
    logic        eng_ready_i = 1'b1;
    logic [7:0]  eng_res_i = '0;
    logic        eng_res_valid_i = 1'b0;
    logic        wr_en_o;
    logic [19:0] wr_addr_o;
    logic [7:0]  wr_data_o;

    sobel_frame_sequencer dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .start_i(start_i),
        .cfg_width_i(cfg_width_i),
        .cfg_height_i(cfg_height_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o),
        .rd_en_o(rd_en_o),
        .rd_addr_o(rd_addr_o),
        .rd_data_i(rd_data_i),
        .eng_start_o(eng_start_o),
        .eng_px_o(eng_px_o),
        .eng_px_valid_o(eng_px_valid_o),
        .eng_load9_o(eng_load9_o),
        .eng_ready_i(eng_ready_i),
        .eng_res_i(eng_res_i),
        .eng_res_valid_i(eng_res_valid_i),
        .wr_en_o(wr_en_o),
        .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int start_cnt = 0;
    int rd_cnt = 0;
    int px_cnt = 0;
    int wr_cnt = 0;
    logic stray = 1'b0;

    logic [19:0] rdq [$];
    logic [8:0]  pxq [$];
    logic [27:0] wrq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] src(input int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    // Expected traffic for a whole frame, in strip order.
    task automatic push_expect(input int w, input int h);
        int s;
        int a;
        for (int c = 0; c <= w - 3; c++) begin
            for (int r = 0; r <= h - 3; r++) begin
                if (r == 0) begin
                    for (int y = 0; y < 3; y++)
                        for (int x = 0; x < 3; x++) begin
                            a = y * w + c + x;
                            rdq.push_back(20'(a));
                            pxq.push_back({1'b1, src(a)});
                        end
                end else begin
                    for (int x = 0; x < 3; x++) begin
                        a = (r + 2) * w + c + x;
                        rdq.push_back(20'(a));
                        pxq.push_back({1'b0, src(a)});
                    end
                end
                s = 0;
                for (int y = 0; y < 3; y++)
                    for (int x = 0; x < 3; x++)
                        s += int'(src((r + y) * w + c + x));
                wrq.push_back({20'((r + 1) * w + c + 1), 8'(s)});
            end
        end
    endtask

    // Source memory: one-cycle read latency.
    logic [7:0] rd_nxt = '0;
    always @(negedge clk) rd_nxt = rd_en_o ? src(int'(rd_addr_o)) : 8'h00;
    always @(posedge clk) rd_data_i <= rd_nxt;

    // Engine model: rebuilds the window and returns its pixel sum.
    logic [7:0] win [9];
    int   n9 = 0;
    int   nu = 0;
    logic pend_v = 1'b0;
    logic [7:0] pend_d = '0;
    always @(negedge clk) begin
        int s;
        if (reset_i) begin
            n9 = 0;
            nu = 0;
            pend_v = 1'b0;
            eng_res_valid_i = 1'b0;
        end else begin
            eng_res_valid_i = pend_v | stray;
            eng_res_i = stray ? 8'hEE : pend_d;
            pend_v = 1'b0;
            if (eng_start_o) begin
                n9 = 0;
                nu = 0;
            end
            if (eng_px_valid_o && eng_ready_i) begin
                if (eng_load9_o) begin
                    win[n9] = eng_px_o;
                    n9++;
                end else begin
                    if (nu == 0)
                        for (int i = 0; i < 6; i++) win[i] = win[i + 3];
                    win[6 + nu] = eng_px_o;
                    nu++;
                end
                if (n9 == 9 || nu == 3) begin
                    n9 = 0;
                    nu = 0;
                    s = 0;
                    for (int i = 0; i < 9; i++) s += int'(win[i]);
                    pend_v = 1'b1;
                    pend_d = 8'(s);
                end
            end
        end
    end

    // Scoreboard monitors.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (done_o) done_cnt++;
            if (eng_start_o) start_cnt++;
            if (rd_en_o) begin
                rd_cnt++;
                if (rdq.size() == 0) chk("rd_extra", 32'(rd_en_o), 32'd0);
                else chk("rd_addr", 32'(rd_addr_o), 32'(rdq.pop_front()));
            end
            if (eng_px_valid_o && eng_ready_i) begin
                px_cnt++;
                if (pxq.size() == 0) chk("px_extra", 32'(eng_px_valid_o), 32'd0);
                else chk("px", 32'({eng_load9_o, eng_px_o}), 32'(pxq.pop_front()));
            end
            if (wr_en_o) begin
                wr_cnt++;
                if (wrq.size() == 0) chk("wr_extra", 32'(wr_en_o), 32'd0);
                else chk("wr", 32'({wr_addr_o, wr_data_o}), 32'(wrq.pop_front()));
            end
        end
    end

    task automatic do_start(input int w, input int h);
        @(posedge clk); #1;
        cfg_width_i = 10'(w);
        cfg_height_i = 10'(h);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) break;
        end
        if (k == 3000) chk("timeout", 32'(done_cnt), 32'(d0 + 1));
    endtask

    task automatic end_checks(input string tag, input int d0);
        repeat (3) @(negedge clk);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(d0 + 1));
        chk({tag, "_rdq"}, 32'(rdq.size()), 32'd0);
        chk({tag, "_pxq"}, 32'(pxq.size()), 32'd0);
        chk({tag, "_wrq"}, 32'(wrq.size()), 32'd0);
        chk({tag, "_idle"}, 32'({busy_o, err_o}), 32'd0);
    endtask

    task automatic run_frame(input string tag, input int w, input int h);
        int d0;
        d0 = done_cnt;
        push_expect(w, h);
        do_start(w, h);
        wait_done(d0);
        end_checks(tag, d0);
    endtask

    logic [63:0] outs;
    assign outs = {busy_o, done_o, err_o, rd_en_o, rd_addr_o, eng_start_o,
                   eng_px_o, eng_px_valid_o, eng_load9_o, wr_en_o,
                   wr_addr_o, wr_data_o} ;

    initial begin
        int d0, s0, w0, r0;

        repeat (2) @(negedge clk);
        chk("reset_outs", 32'(outs), 32'd0);
        @(posedge clk); #1;
        reset_i = 1'b0;

        run_frame("f3x3", 3, 3);
        chk("f3x3_reads", 32'(rd_cnt), 32'd9);
        chk("f3x3_writes", 32'(wr_cnt), 32'd1);

        r0 = rd_cnt;
        w0 = wr_cnt;
        run_frame("f4x4", 4, 4);
        chk("f4x4_reads", 32'(rd_cnt - r0), 32'd24);
        chk("f4x4_writes", 32'(wr_cnt - w0), 32'd4);

        // Rejected configuration.
        d0 = done_cnt;
        s0 = start_cnt;
        r0 = rd_cnt;
        do_start(2, 5);
        @(negedge clk);
        chk("err_check_cycle", 32'({done_o, busy_o}), 32'b01);
        @(negedge clk);
        chk("err_done", 32'({done_o, err_o}), 32'b11);
        @(negedge clk);
        chk("err_hold", 32'({done_o, err_o, busy_o}), 32'b010);
        chk("err_no_reads", 32'(rd_cnt), 32'(r0));
        chk("err_no_engstart", 32'(start_cnt), 32'(s0));
        chk("err_done_cnt", 32'(done_cnt), 32'(d0 + 1));
        run_frame("after_err", 3, 3);

        // Backpressure in the middle of the first 9-pixel load.
        d0 = done_cnt;
        push_expect(5, 4);
        s0 = px_cnt;
        do_start(5, 4);
        for (int k = 0; k < 200 && px_cnt < s0 + 4; k++) @(negedge clk);
        @(posedge clk); #1;
        eng_ready_i = 1'b0;
        r0 = rd_cnt;
        repeat (5) @(posedge clk);
        w0 = rd_cnt;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_reads_max2", 32'(rd_cnt - r0 <= 2), 32'd1);
        chk("stall_reads_late", 32'(rd_cnt), 32'(w0));
        chk("stall_px_head", 32'(eng_px_valid_o), 32'd1);
        eng_ready_i = 1'b1;
        wait_done(d0);
        end_checks("f5x4_stall", d0);

        // Reset in the middle of a frame.
        d0 = done_cnt;
        push_expect(8, 8);
        do_start(8, 8);
        repeat (30) @(posedge clk);
        #1;
        reset_i = 1'b1;
        #1;
        chk("midreset_outs", 32'(outs), 32'd0);
        chk("midreset_outs_hi", 32'(outs >> 32), 32'd0);
        rdq.delete();
        pxq.delete();
        wrq.delete();
        @(posedge clk); #1;
        reset_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("midreset_no_done", 32'(done_cnt), 32'(d0));
        run_frame("after_reset", 5, 3);

        // Start held through a frame, then stray results while idle.
        d0 = done_cnt;
        s0 = start_cnt;
        push_expect(4, 4);
        @(posedge clk); #1;
        cfg_width_i = 10'd4;
        cfg_height_i = 10'd4;
        start_i = 1'b1;
        wait_done(d0);
        @(posedge clk); #1;
        start_i = 1'b0;
        end_checks("held_start", d0);
        chk("held_one_start", 32'(start_cnt), 32'(s0 + 1));
        w0 = wr_cnt;
        @(posedge clk); #1;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        repeat (4) @(negedge clk);
        chk("stray_no_write", 32'(wr_cnt), 32'(w0));
        chk("stray_idle", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
